// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the CPU core.
// Word-addressed RAM with byte-lane writes and combinational read, a small
// MMIO status window, a post-reset clear sweep and completion-flag detection.
//
// Access semantics: the CPU port has no valid/ready handshake. Every cycle
// presents one access: a read of d_mem_addr always happens, and a write
// happens when d_mem_wen != 0. There are no wait states. mem_ready low means
// the RAM is still being swept and the CPU must be held in reset.
module dmem_responder #(
  parameter int          MEM_WORDS      = 1024,
  parameter logic [31:0] DONE_ADDR      = 32'h400,
  parameter logic [31:0] DONE_VALUE     = 32'd1,
  parameter logic [31:0] RES_BASE       = 32'h300,
  parameter int          RES_WORDS      = 10,
  parameter logic [31:0] MMIO_BASE      = 32'h0000_F000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] d_mem_addr,
  input  logic [31:0] d_mem_wdata,
  input  logic [3:0]  d_mem_wen,
  output logic [31:0] d_mem_rdata,
  output logic        mem_ready,
  output logic        done,
  output logic [31:0] done_cycles,
  output logic        err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_WORDS);
  localparam logic [31:0] RES_END   = RES_BASE + 32'(4 * RES_WORDS);
  localparam logic [31:0] DONE_W    = {DONE_ADDR[31:2], 2'b00};
  localparam logic [AW-1:0] LAST_PTR = AW'(MEM_WORDS - 1);

  logic [31:0] mem [MEM_WORDS];

  state_t      state;
  logic [AW-1:0] ptr;
  logic [31:0] cycles;
  logic [31:0] writes;
  logic [31:0] checksum;

  // Address decode; the two low address bits never matter.
  logic [31:0]   word_addr;
  logic [31:0]   mmio_off;
  logic [AW-1:0] widx;
  logic          in_ram, in_mmio, in_res;
  logic          any_wr, full_wr, live;
  logic          ram_wr, ctrl_wr, restart, illegal, complete;
  logic          unused_addr_bits;

  assign word_addr = {d_mem_addr[31:2], 2'b00};
  assign mmio_off  = word_addr - MMIO_BASE;
  assign widx      = d_mem_addr[AW+1:2];
  assign in_ram    = word_addr < RAM_BYTES;
  assign in_mmio   = (word_addr >= MMIO_BASE) && (mmio_off <= 32'h10);
  assign in_res    = (word_addr >= RES_BASE) && (word_addr < RES_END);
  assign any_wr    = d_mem_wen != 4'b0000;
  assign full_wr   = d_mem_wen == 4'b1111;
  assign live      = state != ST_CLEAR;

  // Only RAM writes and full-word CTRL writes are legal, and only after the sweep.
  assign ram_wr   = live && any_wr && in_ram;
  assign ctrl_wr  = live && full_wr && in_mmio && (mmio_off == 32'h10);
  assign restart  = ctrl_wr && d_mem_wdata[0];
  assign illegal  = any_wr && !ram_wr && !ctrl_wr;
  assign complete = (state == ST_RUN) && full_wr && (word_addr == DONE_W) &&
                    (d_mem_wdata == DONE_VALUE);

  assign unused_addr_bits = ^d_mem_addr[1:0];
  assign dbg_state        = state;

  // RAM write port: the sweep owns it during CLEAR, the CPU afterwards.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == ST_CLEAR) begin
        mem[ptr] <= '0;
      end else if (ram_wr) begin
        for (int k = 0; k < 4; k++) begin
          if (d_mem_wen[k]) mem[widx][8*k +: 8] <= d_mem_wdata[8*k +: 8];
        end
      end
    end
  end

  // Control FSM with counters; soft restart overrides everything else.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      ptr         <= '0;
      mem_ready   <= !CLEAR_ON_RESET;
      done        <= 1'b0;
      err         <= 1'b0;
      done_cycles <= '0;
      cycles      <= '0;
      writes      <= '0;
      checksum    <= '0;
    end else begin
      if (illegal) err <= 1'b1;
      case (state)
        ST_CLEAR: begin
          ptr <= ptr + AW'(1);
          if (ptr == LAST_PTR) begin
            state     <= ST_RUN;
            mem_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          if (cycles != 32'hFFFF_FFFF) cycles <= cycles + 32'd1;
          if (ram_wr) writes <= writes + 32'd1;
          if (ram_wr && full_wr && in_res) checksum <= checksum + d_mem_wdata;
          if (complete) begin
            state       <= ST_HALTED;
            done        <= 1'b1;
            // The completion cycle itself is counted.
            done_cycles <= (cycles == 32'hFFFF_FFFF) ? cycles : cycles + 32'd1;
          end
        end
        ST_HALTED: begin
        end
        default: state <= ST_RUN;
      endcase
      if (restart) begin
        state    <= ST_RUN;
        done     <= 1'b0;
        err      <= 1'b0;
        cycles   <= '0;
        writes   <= '0;
        checksum <= '0;
      end
    end
  end

  // Combinational read mux: RAM, MMIO registers, or zero.
  always_comb begin
    d_mem_rdata = '0;
    if (in_ram) begin
      d_mem_rdata = mem[widx];
    end else if (in_mmio) begin
      case (mmio_off[4:2])
        3'd0:    d_mem_rdata = {29'b0, err, done, mem_ready};
        3'd1:    d_mem_rdata = cycles;
        3'd2:    d_mem_rdata = writes;
        3'd3:    d_mem_rdata = checksum;
        default: d_mem_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed vector table, hand-written
// completion/restart/reset sequences, and a randomized phase checked
// against a behavioural model of the memory map.
module tb_dmem_responder;

  localparam logic [31:0] MMIO = 32'h0000_F000;

  logic        clk;
  logic        rst_n;
  logic [31:0] d_mem_addr;
  logic [31:0] d_mem_wdata;
  logic [3:0]  d_mem_wen;
  logic [31:0] d_mem_rdata;
  logic        mem_ready;
  logic        done;
  logic [31:0] done_cycles;
  logic        err;
  logic [1:0]  dbg_state;

  dmem_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_mem_addr (d_mem_addr),
    .d_mem_wdata(d_mem_wdata),
    .d_mem_wen  (d_mem_wen),
    .d_mem_rdata(d_mem_rdata),
    .mem_ready  (mem_ready),
    .done       (done),
    .done_cycles(done_cycles),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] m_mem [1024];
  logic [31:0] m_cycles, m_writes, m_sum, m_done_cycles;
  bit          m_done, m_err, m_halted;

  function automatic void model_clear(input bit err_after);
    for (int i = 0; i < 1024; i++) m_mem[i] = 32'h0;
    m_cycles = 0; m_writes = 0; m_sum = 0; m_done_cycles = 0;
    m_done = 0; m_halted = 0; m_err = err_after;
  endfunction

  // One RUN/HALTED cycle worth of memory-map behaviour.
  function automatic void model_step(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    logic [31:0] wa;
    bit run;
    wa  = {a[31:2], 2'b00};
    run = !m_halted;
    if (run && m_cycles != 32'hFFFF_FFFF) m_cycles++;
    if (w != 4'b0000) begin
      if (wa < 32'h1000) begin
        for (int k = 0; k < 4; k++)
          if (w[k]) m_mem[wa[11:2]][8*k +: 8] = d[8*k +: 8];
        if (run) begin
          m_writes++;
          if (w == 4'hF && wa >= 32'h300 && wa < 32'h328) m_sum += d;
          if (w == 4'hF && wa == 32'h400 && d == 32'd1) begin
            m_halted = 1; m_done = 1; m_done_cycles = m_cycles;
          end
        end
      end else if (wa == MMIO + 32'h10 && w == 4'hF) begin
        if (d[0]) begin
          m_halted = 0; m_done = 0; m_err = 0;
          m_cycles = 0; m_writes = 0; m_sum = 0;
        end
      end else begin
        m_err = 1;
      end
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (wa < 32'h1000)        return m_mem[wa[11:2]];
    if (wa == MMIO)           return {29'b0, m_err, m_done, 1'b1};
    if (wa == MMIO + 32'h4)   return m_cycles;
    if (wa == MMIO + 32'h8)   return m_writes;
    if (wa == MMIO + 32'hC)   return m_sum;
    return 32'h0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    d_mem_addr = a; d_mem_wdata = d; d_mem_wen = w;
    @(posedge clk); #1;
    model_step(a, d, w);
    d_mem_wen = 4'b0000;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    d_mem_addr = a; d_mem_wen = 4'b0000;
    #1;
    chk(name, d_mem_rdata, exp);
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0; d_mem_wen = 4'b0000;
    repeat (5) @(posedge clk);
    #1;
    chk({name, "_ready"}, 32'(mem_ready), 32'd0);
    chk({name, "_done"}, 32'(done), 32'd0);
    chk({name, "_err"}, 32'(err), 32'd0);
    chk({name, "_done_cycles"}, done_cycles, 32'd0);
    rst_n = 1'b1;
  endtask

  // Count cycles until mem_ready; optionally inject one write mid-sweep.
  task automatic sweep_wait(input string name, input int inject_at);
    int n;
    n = 0;
    while (!mem_ready && n < 3000) begin
      if (n == inject_at) begin
        d_mem_addr = 32'h14; d_mem_wdata = 32'hDEAD_BEEF; d_mem_wen = 4'hF;
      end
      @(posedge clk); #1;
      d_mem_wen = 4'b0000;
      n++;
    end
    chk(name, n, 32'd1024);
    model_clear(inject_at >= 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wen;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[20];

  logic [31:0] rv[10];

  initial begin
    logic [31:0] a, d, rexp;
    logic [3:0]  w;

    rst_n = 1'b0; d_mem_addr = 0; d_mem_wdata = 0; d_mem_wen = 0;

    vt[0]  = '{32'h20,        32'h1122_3344, 4'b1111, 32'h20,        32'h1122_3344};
    vt[1]  = '{32'h20,        32'hAABB_CCDD, 4'b0101, 32'h20,        32'h11BB_33DD};
    vt[2]  = '{32'h0,         32'h0,         4'b0000, MMIO + 32'h8,  32'd2};
    vt[3]  = '{32'h2000,      32'h5,         4'b1111, 32'h2000,      32'h0};
    vt[4]  = '{32'h0,         32'h0,         4'b0000, MMIO,          32'h5};
    vt[5]  = '{MMIO + 32'h10, 32'h1,         4'b0011, MMIO,          32'h5};
    vt[6]  = '{MMIO + 32'h4,  32'h123,       4'b1111, MMIO + 32'h8,  32'd2};
    vt[7]  = '{32'h400,       32'h2,         4'b1111, 32'h400,       32'h2};
    vt[8]  = '{32'h400,       32'h1,         4'b0001, 32'h400,       32'h1};
    vt[9]  = '{32'h0,         32'h0,         4'b0000, MMIO,          32'h5};
    vt[10] = '{MMIO + 32'h10, 32'h0,         4'b1111, MMIO,          32'h5};
    vt[11] = '{MMIO + 32'h10, 32'h1,         4'b1111, MMIO,          32'h1};
    vt[12] = '{32'h0,         32'h0,         4'b0000, MMIO + 32'h8,  32'd0};
    vt[13] = '{32'h0,         32'h0,         4'b0000, 32'h20,        32'h11BB_33DD};
    vt[14] = '{32'h2000,      32'h9,         4'b0000, MMIO,          32'h1};
    vt[15] = '{32'h0,         32'h0,         4'b0000, MMIO + 32'h10, 32'h0};
    vt[16] = '{32'h22,        32'hCAFE_F00D, 4'b1111, 32'h20,        32'hCAFE_F00D};
    vt[17] = '{32'hFFC,       32'h77,        4'b1111, 32'hFFC,       32'h77};
    vt[18] = '{32'h1000,      32'h88,        4'b1111, MMIO,          32'h5};
    vt[19] = '{32'h0,         32'h0,         4'b0000, 32'h0,         32'h0};

    rv = '{32'd9, 32'd3, 32'd7, 32'd1, 32'd5, 32'd8, 32'd2, 32'd6, 32'd4, 32'd10};

    // Reset and clear sweep, with a preloaded word that must be wiped.
    do_reset("rst0");
    sweep_wait("sweep0_len", -1);
    do_op(32'h14, 32'hDEAD_BEEF, 4'hF);
    rd_chk("preload", 32'h14, 32'hDEAD_BEEF);
    do_reset("rst1");
    sweep_wait("sweep1_len", -1);
    rd_chk("swept_word", 32'h14, 32'h0);

    // Directed vector table.
    for (int i = 0; i < 20; i++) begin
      do_op(vt[i].addr, vt[i].wdata, vt[i].wen);
      rd_chk($sformatf("vec%0d", i), vt[i].raddr, vt[i].exp);
    end

    // Result checksum and completion at RUN cycle 13.
    do_op(MMIO + 32'h10, 32'h1, 4'hF);
    for (int i = 0; i < 10; i++) do_op(32'h300 + 32'(4 * i), rv[i], 4'hF);
    do_op(32'h0, 32'h0, 4'h0);
    do_op(32'h0, 32'h0, 4'h0);
    rd_chk("checksum", MMIO + 32'hC, 32'd55);
    rd_chk("cycles_pre", MMIO + 32'h4, 32'd12);
    chk("done_pre", 32'(done), 32'd0);
    do_op(32'h400, 32'h1, 4'hF);
    chk("done_set", 32'(done), 32'd1);
    chk("done_cycles", done_cycles, 32'd13);
    repeat (3) do_op(32'h0, 32'h0, 4'h0);
    rd_chk("cycles_frozen", MMIO + 32'h4, 32'd13);
    rd_chk("status_halted", MMIO, 32'h3);
    do_op(32'h40, 32'h0000_ABCD, 4'hF);
    rd_chk("halted_ram_wr", 32'h40, 32'h0000_ABCD);
    rd_chk("halted_writes", MMIO + 32'h8, 32'd11);

    // Restart in HALTED then completion on the very next cycle.
    do_op(MMIO + 32'h10, 32'h1, 4'hF);
    chk("restart_done", 32'(done), 32'd0);
    do_op(32'h400, 32'h1, 4'hF);
    chk("quick_done", 32'(done), 32'd1);
    chk("quick_done_cycles", done_cycles, 32'd1);

    // Randomized phase against the model.
    do_op(MMIO + 32'h10, 32'h1, 4'hF);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0: a = 32'h300 + 32'(4 * $urandom_range(0, 11));
        1: a = 32'h3F8 + 32'(4 * $urandom_range(0, 4));
        2: a = MMIO + 32'(4 * $urandom_range(0, 5));
        3: a = 32'($urandom_range(0, 4095));
        4: a = 32'h1000 + 32'($urandom_range(0, 8191));
        default: a = 32'h400;
      endcase
      w = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      if (a >= MMIO && $urandom_range(0, 3) != 0) w = 4'h0;
      d = ($urandom_range(0, 2) == 0) ? 32'd1 : $urandom();
      d_mem_addr = a; d_mem_wdata = d; d_mem_wen = w;
      #1;
      exp_q.push_back(model_read(a));
      chk("rand_rdata", d_mem_rdata, exp_q.pop_front());
      @(posedge clk); #1;
      model_step(a, d, w);
      d_mem_wen = 4'b0000;
      exp_q.push_back({31'b0, m_done});
      exp_q.push_back({31'b0, m_err});
      exp_q.push_back(m_done_cycles);
      chk("rand_done", 32'(done), exp_q.pop_front());
      chk("rand_err", 32'(err), exp_q.pop_front());
      chk("rand_done_cycles", done_cycles, exp_q.pop_front());
      if (i % 8 == 0) begin
        rexp = model_read(MMIO + 32'h4);
        rd_chk("rand_cycles", MMIO + 32'h4, rexp);
        rexp = model_read(MMIO + 32'h8);
        rd_chk("rand_writes", MMIO + 32'h8, rexp);
        rexp = model_read(MMIO + 32'hC);
        rd_chk("rand_checksum", MMIO + 32'hC, rexp);
      end
    end

    // Reset mid-sweep at ptr 300, then a write during CLEAR.
    do_reset("rst2");
    repeat (300) @(posedge clk);
    #1;
    chk("mid_sweep_ready", 32'(mem_ready), 32'd0);
    do_reset("rst3");
    sweep_wait("sweep3_len", 10);
    chk("clear_wr_err", 32'(err), 32'd1);
    rd_chk("clear_wr_dropped", 32'h14, 32'h0);
    rd_chk("swept_result", 32'h300, 32'h0);
    rd_chk("status_after", MMIO, 32'h5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
